// File: rtl/generic_sram_be_if.sv
// Request/response bundle for generic_sram_be. The master issues the
// requests; the slave (the SRAM) returns read data and the init status.
interface generic_sram_be_if #(
  parameter int WORD_W  = 32,
  parameter int WORDS_N = 256,
  parameter int BYTE_W  = 8
);
  localparam int ADDR_W  = $clog2(WORDS_N);
  localparam int LANES_N = WORD_W / BYTE_W;

  logic               ce;
  logic               rnw;
  logic [ADDR_W-1:0]  addr;
  logic [WORD_W-1:0]  din;
  logic [LANES_N-1:0] wmask;
  logic [WORD_W-1:0]  dout;
  logic               dout_vld;
  logic               init_busy;

  modport master (
    output ce, rnw, addr, din, wmask,
    input  dout, dout_vld, init_busy
  );

  modport slave (
    input  ce, rnw, addr, din, wmask,
    output dout, dout_vld, init_busy
  );
endinterface

// File: rtl/generic_sram_be.sv
// Single-port SRAM with byte-lane write mask, configurable read latency and
// a self-clearing init sweep after reset. Idle output cycles show the
// inverse of the last valid read word so stale data is never mistaken for
// a fresh result. Depths that are not a power of two ignore writes beyond
// the top word and return INIT_VAL for reads there.
module generic_sram_be #(
  parameter int                WORD_W   = 32,
  parameter int                WORDS_N  = 256,
  parameter int                BYTE_W   = 8,
  parameter int                RD_LAT   = 1,
  parameter logic [WORD_W-1:0] INIT_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  generic_sram_be_if.slave  bus
);

  localparam int ADDR_W  = $clog2(WORDS_N);
  localparam int LANES_N = WORD_W / BYTE_W;
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(WORDS_N);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS_N - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e              state_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   init_cnt_q;
  logic [WORD_W-1:0]   mem [WORDS_N];

  logic                in_range;
  logic                acc_rd;
  logic                acc_wr;
  logic [WORD_W-1:0]   rd_word;

  logic                tail_vld;
  logic [WORD_W-1:0]   tail_dat;

  logic                dout_vld_q, dout_vld_d;
  logic [WORD_W-1:0]   dout_q,     dout_d;
  logic [WORD_W-1:0]   last_vld_q, last_vld_d;

  // Request decode: accept only in RUN and outside reset; read word is
  // taken from the array at the accepting edge.
  // NOTE: every output of a combinational block gets a value on every path
  // (here by full assignment) so no latch is inferred.
  always_comb begin
    in_range = ({1'b0, bus.addr} < DEPTH);
    acc_rd   = !rst && (state_q == ST_RUN) && bus.ce &&  bus.rnw;
    acc_wr   = !rst && (state_q == ST_RUN) && bus.ce && !bus.rnw && in_range;
    rd_word  = in_range ? mem[bus.addr] : INIT_VAL;
  end

  // Init/run controller: sweep every word once after reset, then serve.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      busy_q     <= 1'b1;
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      if (init_cnt_q == LAST_IDX) begin
        state_q <= ST_RUN;
        busy_q  <= 1'b0;
      end else begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end
    end
  end

  // Storage: init sweep writes whole words, run-time writes honour the mask.
  // NOTE: the array has no reset; the init sweep establishes its contents,
  // and a reset term would stop it mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_INIT)) begin
      mem[init_cnt_q] <= INIT_VAL;
    end else if (acc_wr) begin
      for (int l = 0; l < LANES_N; l++) begin
        if (bus.wmask[l]) begin
          mem[bus.addr][l*BYTE_W +: BYTE_W] <= bus.din[l*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read pipeline: RD_LAT-1 delay stages ahead of the output register.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign tail_vld = acc_rd;
      assign tail_dat = rd_word;
    end else begin : g_pipe
      logic [RD_LAT-2:0]             pv_q;
      logic [RD_LAT-2:0][WORD_W-1:0] pd_q;

      // Valid bits are reset so a reset drops every in-flight read.
      always_ff @(posedge clk) begin
        if (rst) begin
          pv_q <= '0;
        end else begin
          pv_q[0] <= acc_rd;
          for (int k = 1; k < RD_LAT - 1; k++) begin
            pv_q[k] <= pv_q[k-1];
          end
        end
      end

      // Data follows the valid bits; its value only matters when valid.
      always_ff @(posedge clk) begin
        pd_q[0] <= rd_word;
        for (int k = 1; k < RD_LAT - 1; k++) begin
          pd_q[k] <= pd_q[k-1];
        end
      end

      assign tail_vld = pv_q[RD_LAT-2];
      assign tail_dat = pd_q[RD_LAT-2];
    end
  endgenerate

  // Output next-state: last valid word includes the one shown right now.
  always_comb begin
    last_vld_d = dout_vld_q ? dout_q : last_vld_q;
    dout_vld_d = tail_vld;
    dout_d     = tail_vld ? tail_dat : ~last_vld_d;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      last_vld_q <= '0;
    end else begin
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.init_busy = busy_q;

endmodule

// File: doc/generic_sram_be.md
GENERIC_SRAM_BE -- requirements
Module: generic_sram_be

Interface
REQ-001 SHALL have parameter WORD_W, default 32, word width in bits; must be a multiple of BYTE_W.
REQ-002 SHALL have parameter WORDS_N, default 256, word count; ADDR_W = $clog2(WORDS_N) is a localparam.
REQ-003 SHALL have parameter BYTE_W, default 8, write-mask lane width; LANES_N = WORD_W/BYTE_W is a localparam.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-005 SHALL have parameter INIT_VAL, default '0, WORD_W-bit value written to every word by the init sweep.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port ce  input  1  request valid.
REQ-009 SHALL have port rnw  input  1  1 = read, 0 = write.
REQ-010 SHALL have port addr  input  ADDR_W  word address.
REQ-011 SHALL have port din  input  WORD_W  write data.
REQ-012 SHALL have port wmask  input  LANES_N  per-lane write enable; bit i covers din[i*BYTE_W +: BYTE_W].
REQ-013 SHALL have port dout  output  WORD_W  read data, registered.
REQ-014 SHALL have port dout_vld  output  1  dout holds read data this cycle.
REQ-015 SHALL have port init_busy  output  1  init sweep in progress; requests are ignored.

Function
REQ-016 SHALL implement a two-state FSM: INIT and RUN; init_busy = (state == INIT).
REQ-017 In INIT, SHALL write INIT_VAL to the word at init counter, one word per cycle, counting 0..WORDS_N-1; INIT -> RUN on the cycle that writes WORDS_N-1.
REQ-018 In INIT, SHALL ignore ce/rnw/addr/din/wmask entirely; no memory update, no dout_vld.
REQ-019 SHALL accept a request in RUN when ce=1; there is no back-pressure and one request is accepted per cycle.
REQ-020 Accepted write SHALL update only the lanes whose wmask bit is 1, visible to reads accepted on the next cycle onward; wmask=0 is a legal no-op.
REQ-021 Accepted read SHALL present mem[addr] on dout with dout_vld=1 exactly RD_LAT cycles after the accepting edge; back-to-back reads give back-to-back valid data.
REQ-022 Read data SHALL be sampled at acceptance; a write to the same address accepted later does not alter the in-flight read.
REQ-023 In any cycle dout_vld=0, dout SHALL equal the bitwise inverse of the last valid dout (last_vld_r), never stale-correct data.
REQ-024 last_vld_r SHALL update only on cycles with dout_vld=1.
REQ-025 Addresses >= WORDS_N (non-power-of-2 depth) SHALL be ignored for writes and return INIT_VAL on reads.

Reset
REQ-026 At a posedge with rst=1: state <= INIT, init counter <= 0, read pipeline valid bits <= 0, dout <= 0, last_vld_r <= 0, dout_vld <= 0.
REQ-027 init_busy SHALL be 1 in the cycle after reset and for exactly WORDS_N cycles after rst deasserts.
REQ-028 Reset mid-sweep or mid-read SHALL restart the sweep at word 0 and drop all in-flight reads (no dout_vld).
REQ-029 After reset, dout SHALL read all-ones from the first non-valid cycle (inverse of last_vld_r=0).

Verification
REQ-030 Init: WORDS_N=16, INIT_VAL=32'hA5A5_A5A5, rst 1 cycle -> init_busy high 16 cycles; reads of addr 0..15 all return A5A5_A5A5.
REQ-031 Masked write: write 32'h1122_3344 mask 4'b1111 to addr 3, then 32'hFFFF_FFFF mask 4'b0101 -> read addr 3 returns 32'h11FF_33FF.
REQ-032 Latency: RD_LAT=3, reads of addr 1,2,3 on consecutive cycles -> dout_vld high 3 consecutive cycles starting 3 cycles after the first, data in order.
REQ-033 Scramble: after valid read of 32'h0000_00FF, idle cycle -> dout=32'hFFFF_FF00, dout_vld=0.
REQ-034 Ordering: read addr 5 (holds 7) then write 9 to addr 5 next cycle, RD_LAT=2 -> read returns 7; subsequent read returns 9.
REQ-035 Reset mid-op: rst asserted with 2 reads in flight and sweep complete -> no dout_vld, init_busy re-asserts for WORDS_N cycles, memory reads INIT_VAL.
